// File: rtl/order_fetch_resp_if.sv
// -----------------------------------------------------------------------------
// order_fetch_resp_if
// Purpose : groups the fetch request/response handshake and the program-load
//           write port of order_fetch_resp into one bundle.
// Signals (named from the fetch block's point of view):
//   i_reqvalid  / i_reqaddr      fetch request from the PC side
//   o_reqready                   request accepted when i_reqvalid & o_reqready
//   i_flush                      drop outstanding request/response
//   o_rspvalid / o_rsporder / o_rspaddr / o_rsperr   response to IF/ID
//   i_rspready                   consumer takes the response (0 = stall)
//   i_loaden / i_loadaddr / i_loaddata               program-load write
// Modports: master = PC / consumer / loader side, slave = fetch block.
// -----------------------------------------------------------------------------
interface order_fetch_resp_if #(
   parameter int unsigned DEPTH_LOG2 = 10
);
   logic                  i_reqvalid;
   logic [31:0]           i_reqaddr;
   logic                  o_reqready;
   logic                  i_flush;
   logic                  o_rspvalid;
   logic [31:0]           o_rsporder;
   logic [31:0]           o_rspaddr;
   logic                  o_rsperr;
   logic                  i_rspready;
   logic                  i_loaden;
   logic [DEPTH_LOG2-1:0] i_loadaddr;
   logic [31:0]           i_loaddata;

   modport master (
      output i_reqvalid, i_reqaddr, i_flush, i_rspready,
             i_loaden, i_loadaddr, i_loaddata,
      input  o_reqready, o_rspvalid, o_rsporder, o_rspaddr, o_rsperr
   );

   modport slave (
      input  i_reqvalid, i_reqaddr, i_flush, i_rspready,
             i_loaden, i_loadaddr, i_loaddata,
      output o_reqready, o_rspvalid, o_rsporder, o_rspaddr, o_rsperr
   );
endinterface

// File: rtl/order_fetch_resp.sv
// -----------------------------------------------------------------------------
// order_fetch_resp
// Purpose : instruction fetch responder. Accepts one fetch request at a time,
//           waits WAIT_STATES cycles, then presents the instruction word read
//           from an internal program memory (or an error/NOP for a misaligned
//           or out-of-range address). The program memory is written through
//           a separate load port at any time.
// Ports   :
//   i_clk     rising-edge clock
//   i_rst     synchronous active-high reset (memory contents are kept)
//   io_fetch  order_fetch_resp_if.slave : request, response, flush and load
// Parameters:
//   DEPTH_LOG2   log2 of the instruction-word count
//   WAIT_STATES  extra latency cycles, 0..7
//   BASE_ADDR    byte address of word 0
// -----------------------------------------------------------------------------
module order_fetch_resp #(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h00010000
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   order_fetch_resp_if.slave       io_fetch
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [2:0]  WS    = WAIT_STATES[2:0];
   // Byte span of the memory, one bit wider so a large DEPTH cannot wrap.
   localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

   logic [31:0]           r_mem [DEPTH];

   logic [1:0]            r_state;
   logic [2:0]            r_cnt;
   logic [31:0]           r_req_addr;
   logic [31:0]           r_rsp_order;
   logic [31:0]           r_rsp_addr;
   logic                  r_rsp_err;

   logic                  w_req_ready;
   logic                  w_accept;
   logic                  w_enter_resp;
   logic [31:0]           w_fetch_addr;
   logic [31:0]           w_offset;
   logic                  w_fetch_ok;
   logic [DEPTH_LOG2-1:0] w_index;
   logic [1:0]            w_state_next;
   logic [2:0]            w_cnt_next;

   // Handshake: the slot is free in IDLE, or in RESP when the current
   // response is being consumed this cycle. A flush edge accepts nothing.
   always_comb begin
      w_req_ready = ((r_state == S_IDLE) ||
                     ((r_state == S_RESP) && io_fetch.i_rspready)) &&
                    !io_fetch.i_flush;
      w_accept    = io_fetch.i_reqvalid && w_req_ready;
   end

   // Next state and wait counter.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if (io_fetch.i_flush) begin
         w_state_next = S_IDLE;
         w_cnt_next   = 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_state_next = (WS == 3'd0) ? S_RESP : S_WAIT;
                  w_cnt_next   = WS;
               end
            end
            S_WAIT: begin
               if (r_cnt <= 3'd1) begin
                  w_state_next = S_RESP;
                  w_cnt_next   = 3'd0;
               end else begin
                  w_cnt_next   = r_cnt - 3'd1;
               end
            end
            S_RESP: begin
               if (io_fetch.i_rspready) begin
                  if (w_accept) begin
                     w_state_next = (WS == 3'd0) ? S_RESP : S_WAIT;
                     w_cnt_next   = WS;
                  end else begin
                     w_state_next = S_IDLE;
                  end
               end
            end
            default: begin
               w_state_next = S_IDLE;
               w_cnt_next   = 3'd0;
            end
         endcase
      end
   end

   // The response registers load on the edge that enters RESP. With no wait
   // states that is the accept edge itself, so the live request address is
   // used; otherwise the address latched at acceptance.
   always_comb begin
      w_enter_resp = (w_state_next == S_RESP) && !io_fetch.i_flush &&
                     ((r_state == S_WAIT) || w_accept);
      w_fetch_addr = (r_state == S_WAIT) ? r_req_addr : io_fetch.i_reqaddr;
      w_offset     = w_fetch_addr - BASE_ADDR;
      w_fetch_ok   = (w_fetch_addr[1:0] == 2'b00) &&
                     (w_fetch_addr >= BASE_ADDR) &&
                     ({1'b0, w_offset} < SPAN);
      w_index      = w_offset[DEPTH_LOG2+1:2];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 3'd0;
         r_req_addr <= 32'h0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         if (w_accept) begin
            r_req_addr <= io_fetch.i_reqaddr;
         end
      end
   end

   // Program memory: write-only port, never reset. The read below uses the
   // pre-edge contents, so a same-edge write returns the old word.
   always_ff @(posedge i_clk) begin
      if (io_fetch.i_loaden) begin
         r_mem[io_fetch.i_loadaddr] <= io_fetch.i_loaddata;
      end
   end

   // Registered read; the output is held while the consumer stalls because
   // it only reloads on entry to RESP.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_order <= 32'h0;
         r_rsp_addr  <= 32'h0;
         r_rsp_err   <= 1'b0;
      end else if (w_enter_resp) begin
         r_rsp_order <= w_fetch_ok ? r_mem[w_index] : 32'h0;
         r_rsp_addr  <= w_fetch_addr;
         r_rsp_err   <= !w_fetch_ok;
      end
   end

   assign io_fetch.o_reqready = w_req_ready;
   assign io_fetch.o_rspvalid = (r_state == S_RESP);
   assign io_fetch.o_rsporder = r_rsp_order;
   assign io_fetch.o_rspaddr  = r_rsp_addr;
   assign io_fetch.o_rsperr   = r_rsp_err;

endmodule

// File: tb/tb_order_fetch_resp.sv
// Three builds (WAIT_STATES = 0, 1, 3) share one stimulus stream. A
// transaction-level model (pending request with a remaining-latency count,
// at most one visible response, a plain memory array) predicts every output.
module tb_order_fetch_resp;

   localparam int unsigned D    = 6;
   localparam int unsigned NW   = 1 << D;
   localparam logic [31:0] BASE = 32'h00010000;
   localparam int          NI   = 3;

   logic          clk;
   logic          rst;
   logic          reqvalid;
   logic [31:0]   reqaddr;
   logic          flush;
   logic          rspready;
   logic          loaden;
   logic [D-1:0]  loadaddr;
   logic [31:0]   loaddata;

   logic          rdy_a   [NI];
   logic          rv_a    [NI];
   logic [31:0]   order_a [NI];
   logic [31:0]   addr_a  [NI];
   logic          err_a   [NI];

   int n_cmp = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int unsigned WS = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
      order_fetch_resp_if #(.DEPTH_LOG2(D)) bus ();
      assign bus.i_reqvalid = reqvalid;
      assign bus.i_reqaddr  = reqaddr;
      assign bus.i_flush    = flush;
      assign bus.i_rspready = rspready;
      assign bus.i_loaden   = loaden;
      assign bus.i_loadaddr = loadaddr;
      assign bus.i_loaddata = loaddata;
      assign rdy_a[gi]      = bus.o_reqready;
      assign rv_a[gi]       = bus.o_rspvalid;
      assign order_a[gi]    = bus.o_rsporder;
      assign addr_a[gi]     = bus.o_rspaddr;
      assign err_a[gi]      = bus.o_rsperr;
      order_fetch_resp #(
         .DEPTH_LOG2 (D),
         .WAIT_STATES(WS),
         .BASE_ADDR  (BASE)
      ) dut (
         .i_clk   (clk),
         .i_rst   (rst),
         .io_fetch(bus.slave)
      );
   end

   // ---------------- reference model ----------------
   logic [31:0] mem_m [NW];
   bit          m_valid = 1'b0;
   bit          m_has   [NI];
   bit          m_pend  [NI];
   int          m_left  [NI];
   logic [31:0] m_paddr [NI];
   logic [31:0] m_order [NI];
   logic [31:0] m_addr  [NI];
   logic        m_err   [NI];
   bit          m_known [NI];

   function automatic int ws_of(int i);
      return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
   endfunction

   function automatic bit fetch_ok(logic [31:0] a);
      longint la = longint'(a);
      longint lb = longint'(BASE);
      return (a[1:0] == 2'b00) && (la >= lb) && (la < lb + 4 * longint'(NW));
   endfunction

   function automatic bit exp_rdy(int i);
      return !m_pend[i] && (!m_has[i] || rspready) && !flush;
   endfunction

   function automatic void respond(int i, logic [31:0] a);
      logic [31:0] off;
      m_has[i]   = 1'b1;
      m_known[i] = 1'b1;
      m_addr[i]  = a;
      if (fetch_ok(a)) begin
         off        = (a - BASE) >> 2;
         m_order[i] = mem_m[off[D-1:0]];
         m_err[i]   = 1'b0;
      end else begin
         m_order[i] = 32'h0;
         m_err[i]   = 1'b1;
      end
   endfunction

   function automatic void model_edge();
      bit acc;
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            m_has[i] = 0; m_pend[i] = 0; m_left[i] = 0;
            m_order[i] = 32'h0; m_addr[i] = 32'h0; m_err[i] = 1'b0;
            m_known[i] = 1'b1;
         end else if (flush) begin
            m_has[i] = 0; m_pend[i] = 0; m_known[i] = 0;
         end else begin
            acc = reqvalid && exp_rdy(i);
            if (m_has[i] && rspready) begin
               m_has[i] = 0; m_known[i] = 0;
            end
            if (m_pend[i]) begin
               m_left[i] = m_left[i] - 1;
               if (m_left[i] == 0) begin
                  m_pend[i] = 0;
                  respond(i, m_paddr[i]);
               end
            end
            if (acc) begin
               if (ws_of(i) == 0) begin
                  respond(i, reqaddr);
               end else begin
                  m_pend[i]  = 1'b1;
                  m_left[i]  = ws_of(i);
                  m_paddr[i] = reqaddr;
               end
            end
         end
      end
      if (rst) m_valid = 1'b1;
      // Loads land after the reads of this edge: same-edge read sees old data.
      if (loaden) mem_m[loadaddr] = loaddata;
   endfunction

   task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, inst, act, exp, $time);
      end
   endtask

   // Compare current outputs against the model, advance the model by the
   // inputs now applied, then move one clock (to the next falling edge).
   task automatic step();
      #1;
      if (m_valid) begin
         for (int i = 0; i < NI; i++) begin
            if (!rst) chk("reqready", i, 32'(rdy_a[i]), 32'(exp_rdy(i)));
            chk("rspvalid", i, 32'(rv_a[i]), 32'(m_has[i]));
            if (m_has[i] || m_known[i]) begin
               chk("rsporder", i, order_a[i], m_order[i]);
               chk("rspaddr", i, addr_a[i], m_addr[i]);
               chk("rsperr", i, 32'(err_a[i]), 32'(m_err[i]));
            end
            if (m_has[i] && rspready && !rst && !flush)
               $display("rsp inst=%0d addr=%h order=%h err=%0d t=%0t",
                        i, addr_a[i], order_a[i], err_a[i], $time);
         end
      end
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic steps(int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic req1(logic [31:0] a);
      reqvalid = 1'b1; reqaddr = a;
      step();
      reqvalid = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r = $urandom_range(0, 19);
      logic [31:0] a = BASE + 32'(4 * $urandom_range(0, NW - 1));
      if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
      else if (r == 1) a = BASE + 32'(4 * $urandom_range(NW, NW + 8));
      else if (r == 2) a = a + 32'($urandom_range(1, 3));
      return a;
   endfunction

   initial begin
      rst = 1'b1; reqvalid = 1'b0; reqaddr = 32'h0; flush = 1'b0;
      rspready = 1'b1; loaden = 1'b0; loadaddr = '0; loaddata = 32'h0;
      @(negedge clk);
      steps(2);
      rst = 1'b0;
      #1;
      chk("reset_rspvalid", 1, 32'(rv_a[1]), 32'h0);
      chk("reset_rsporder", 1, order_a[1], 32'h0);
      chk("reset_reqready", 1, 32'(rdy_a[1]), 32'h1);

      // program load
      for (int w = 0; w < int'(NW); w++) begin
         loaden = 1'b1; loadaddr = D'(w);
         case (w)
            0: loaddata = 32'h20080005;
            1: loaddata = 32'h8C090004;
            2: loaddata = 32'h12345678;
            3: loaddata = 32'h0BADF00D;
            default: loaddata = $urandom;
         endcase
         step();
      end
      loaden = 1'b0;

      // basic fetch and per-build latency
      req1(32'h00010000);
      chk("lat0_valid", 0, 32'(rv_a[0]), 32'h1);
      chk("lat0_order", 0, order_a[0], 32'h20080005);
      chk("lat1_early", 1, 32'(rv_a[1]), 32'h0);
      step();
      chk("lat1_valid", 1, 32'(rv_a[1]), 32'h1);
      chk("lat1_order", 1, order_a[1], 32'h20080005);
      chk("lat1_addr", 1, addr_a[1], 32'h00010000);
      chk("lat1_err", 1, 32'(err_a[1]), 32'h0);
      step();
      chk("lat3_early", 2, 32'(rv_a[2]), 32'h0);
      step();
      chk("lat3_valid", 2, 32'(rv_a[2]), 32'h1);
      steps(2);

      // misaligned and below-base fetches
      req1(32'h00010002);
      step();
      chk("misalign_err", 1, 32'(err_a[1]), 32'h1);
      chk("misalign_order", 1, order_a[1], 32'h0);
      steps(3);
      req1(32'h0000FFFC);
      step();
      chk("below_err", 1, 32'(err_a[1]), 32'h1);
      chk("below_addr", 1, addr_a[1], 32'h0000FFFC);
      steps(3);

      // stall for 3 cycles, then back-to-back accept of word 1
      rspready = 1'b0;
      req1(32'h00010000);
      steps(3);
      reqvalid = 1'b1; reqaddr = 32'h00010004;
      steps(3);
      #1;
      chk("stall_reqready", 1, 32'(rdy_a[1]), 32'h0);
      chk("stall_order", 1, order_a[1], 32'h20080005);
      rspready = 1'b1;
      step();
      reqvalid = 1'b0;
      chk("b2b_ws0_order", 0, order_a[0], 32'h8C090004);
      step();
      chk("b2b_ws1_valid", 1, 32'(rv_a[1]), 32'h1);
      chk("b2b_ws1_order", 1, order_a[1], 32'h8C090004);
      steps(4);

      // flush during WAIT, then during RESP
      req1(32'h00010000);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_wait_v1", 1, 32'(rv_a[1]), 32'h0);
      steps(5);
      chk("flush_wait_stale", 2, 32'(rv_a[2]), 32'h0);
      req1(32'h00010000);
      rspready = 1'b0;
      step();
      flush = 1'b1; rspready = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_resp_v1", 1, 32'(rv_a[1]), 32'h0);
      steps(5);
      chk("flush_resp_stale", 2, 32'(rv_a[2]), 32'h0);

      // reset while a response is presented
      req1(32'h00010004);
      rspready = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; rspready = 1'b1;
      #1;
      chk("rst_resp_valid", 1, 32'(rv_a[1]), 32'h0);
      chk("rst_resp_order", 1, order_a[1], 32'h0);
      chk("rst_resp_addr", 1, addr_a[1], 32'h0);
      chk("rst_resp_ready", 1, 32'(rdy_a[1]), 32'h1);
      req1(32'h00010004);
      step();
      chk("mem_kept", 1, order_a[1], 32'h8C090004);
      steps(3);

      // load on the read edge returns old data, later fetch returns new
      reqvalid = 1'b1; reqaddr = 32'h00010008;
      loaden = 1'b1; loadaddr = D'(2); loaddata = 32'hDEADBEEF;
      step();
      reqvalid = 1'b0; loaden = 1'b0;
      chk("wr_same_edge_ws0", 0, order_a[0], 32'h12345678);
      step();
      chk("wr_before_read_ws1", 1, order_a[1], 32'hDEADBEEF);
      steps(3);
      req1(32'h0001000C);
      loaden = 1'b1; loadaddr = D'(3); loaddata = 32'h11111111;
      step();
      loaden = 1'b0;
      chk("wr_same_edge_ws1", 1, order_a[1], 32'h0BADF00D);
      steps(3);
      req1(32'h0001000C);
      chk("wr_new_ws0", 0, order_a[0], 32'h11111111);
      step();
      chk("wr_new_ws1", 1, order_a[1], 32'h11111111);
      steps(3);

      // randomized traffic
      for (int n = 0; n < 2500; n++) begin
         rst      = ($urandom_range(0, 199) == 0);
         flush    = ($urandom_range(0, 19) == 0);
         rspready = ($urandom_range(0, 3) != 0);
         reqvalid = ($urandom_range(0, 9) < 7);
         reqaddr  = rand_addr();
         loaden   = !rst && ($urandom_range(0, 7) == 0);
         loadaddr = D'($urandom_range(0, NW - 1));
         loaddata = $urandom;
         step();
      end
      rst = 1'b0; flush = 1'b0; reqvalid = 1'b0; loaden = 1'b0; rspready = 1'b1;
      steps(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
